// File: rtl/sample_ring_writer_pkg.sv
// Shared types and constants for the sample ring writer.
package sample_ring_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_e;

  localparam logic [3:0]  BE_ALL   = 4'hF;
  localparam logic [15:0] DROP_SAT = 16'hFFFF;
endpackage

// File: rtl/sample_ring_writer_if.sv
// Sample stream sink plus RAM write-master bus of the ring writer.
interface sample_ring_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;

  // Writer side: consumes samples, drives the RAM
  modport master (
    input  snk_data, snk_valid,
    output snk_ready,
    output mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken
  );

  // Environment side: sample source and RAM
  modport slave (
    output snk_data, snk_valid,
    input  snk_ready,
    input  mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken
  );
endinterface

// File: rtl/sample_ring_writer_fifo.sv
// Small synchronous FIFO buffering samples between the stream and the RAM port.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [PW:0]       cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  // Pointers and occupancy; flush drops everything, including a same-cycle push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/sample_ring_writer.sv
// Circular sample logger feeding a 1-cycle single-port RAM, with zero-fill sweep and hold.
module sample_ring_writer import sample_ring_pkg::*; #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 25000,
  parameter int BASE_WORD    = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              mem_hold,
  sample_ring_writer_if.master bus,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] count,
  output logic              wrapped,
  output logic [15:0]       drop_cnt,
  output logic              busy,
  output logic              clear_done
);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, sweep_q, sweep_d, ma_q, ma_d;
  logic [DATA_W-1:0] md_q, md_d, fifo_rdata;
  logic [15:0]       drop_q, drop_d;
  logic              wrap_q, wrap_d, mw_q, mw_d, done_q, done_d;
  logic              ready, fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;

  assign ready     = (state_q == RUN) && ((DROP_ON_FULL != 0) || !fifo_full);
  assign fifo_push = bus.snk_valid && ready;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.snk_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, ring bookkeeping and the RAM command for the next cycle
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    sweep_d    = sweep_q;
    drop_d     = drop_q;
    mw_d       = 1'b0;
    ma_d       = ma_q;
    md_d       = md_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (state_q == RUN && DROP_ON_FULL != 0 && bus.snk_valid && fifo_full && drop_q != DROP_SAT)
      drop_d = drop_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (clear)      state_d = CLEAR;
        else if (start) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (clear) begin
          state_d = CLEAR;                 // queued samples are discarded, not written
        end else begin
          if (state_q == RUN && stop)            state_d = DRAIN;
          else if (state_q == DRAIN && fifo_empty) state_d = IDLE;
          if (!fifo_empty && !mem_hold) begin
            fifo_pop = 1'b1;
            mw_d     = 1'b1;
            ma_d     = BASE + ptr_q;
            md_d     = fifo_rdata;
            if (ptr_q == LAST) begin
              ptr_d  = '0;
              wrap_d = 1'b1;
            end else begin
              ptr_d  = ptr_q + ONE;
            end
            if (cnt_q != DEPTH_W) cnt_d = cnt_q + ONE;
          end
        end
      end
      CLEAR: begin
        if (!mem_hold) begin
          mw_d = 1'b1;
          ma_d = BASE + sweep_q;
          md_d = '0;
          if (sweep_q == LAST) begin
            sweep_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            sweep_d = sweep_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering CLEAR restarts the ring from scratch
    if (state_d == CLEAR && state_q != CLEAR) begin
      fifo_flush = 1'b1;
      ptr_d      = '0;
      cnt_d      = '0;
      wrap_d     = 1'b0;
      sweep_d    = '0;
    end
  end

  // State and registered RAM master outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sweep_q <= '0;
      drop_q  <= '0;
      mw_q    <= 1'b0;
      ma_q    <= '0;
      md_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      sweep_q <= sweep_d;
      drop_q  <= drop_d;
      mw_q    <= mw_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      done_q  <= done_d;
    end
  end

  assign bus.snk_ready      = ready;
  assign bus.mem_write      = mw_q;
  assign bus.mem_chipselect = mw_q;
  assign bus.mem_byteenable = mw_q ? BE_ALL : 4'h0;
  assign bus.mem_address    = ma_q;
  assign bus.mem_writedata  = md_q;
  assign bus.mem_clken      = 1'b1;
  assign wr_ptr     = ptr_q;
  assign count      = cnt_q;
  assign wrapped    = wrap_q;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q != IDLE);
  assign clear_done = done_q;
endmodule

// File: tb/tb_sample_ring_writer.sv
// Directed bench: dut_a (DEPTH=8, backpressure) and dut_b (DEPTH=8, drop on full).
`timescale 1ns/1ps
module tb_sample_ring_writer;
  import sample_ring_pkg::*;
  localparam int DW = 32;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 0, stop_a = 0, clear_a = 0, hold_a = 0;
  logic start_b = 0, stop_b = 0, clear_b = 0, hold_b = 0;
  logic [AW-1:0] wr_ptr_a, count_a, wr_ptr_b, count_b;
  logic wrapped_a, busy_a, done_a, wrapped_b, busy_b, done_b;
  logic [15:0] drop_a, drop_b;

  sample_ring_writer_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  sample_ring_writer_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  sample_ring_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .BASE_WORD(0),
                       .FIFO_DEPTH(4), .DROP_ON_FULL(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a), .clear(clear_a),
    .mem_hold(hold_a), .bus(ifa), .wr_ptr(wr_ptr_a), .count(count_a), .wrapped(wrapped_a),
    .drop_cnt(drop_a), .busy(busy_a), .clear_done(done_a));

  sample_ring_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .BASE_WORD(0),
                       .FIFO_DEPTH(4), .DROP_ON_FULL(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b), .clear(clear_b),
    .mem_hold(hold_b), .bus(ifb), .wr_ptr(wr_ptr_b), .count(count_b), .wrapped(wrapped_b),
    .drop_cnt(drop_b), .busy(busy_b), .clear_done(done_b));

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
  } wr_t;

  wr_t log_a[$];
  wr_t log_b[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // RAM-side view: every write strobe seen at a clock edge
  always @(posedge clk) begin
    if (ifa.mem_write === 1'b1) log_a.push_back({ifa.mem_address, ifa.mem_writedata, ifa.mem_byteenable});
    if (ifb.mem_write === 1'b1) log_b.push_back({ifb.mem_address, ifb.mem_writedata, ifb.mem_byteenable});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_a = 0; stop_a = 0; clear_a = 0; hold_a = 0;
    start_b = 0; stop_b = 0; clear_b = 0; hold_b = 0;
    ifa.snk_valid = 0; ifa.snk_data = '0;
    ifb.snk_valid = 0; ifb.snk_data = '0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    log_a.delete();
    log_b.delete();
    reset_n = 1;
  endtask

  task automatic test_reset();
    start_a = 0; stop_a = 0; clear_a = 0; hold_a = 0;
    start_b = 0; stop_b = 0; clear_b = 0; hold_b = 0;
    ifa.snk_valid = 0; ifa.snk_data = '0;
    ifb.snk_valid = 0; ifb.snk_data = '0;
    reset_n = 0;
    cyc(2);
    n_chk++; if (ifa.mem_write !== 1'b0 || ifa.mem_chipselect !== 1'b0 || ifa.mem_byteenable !== 4'h0) begin
      n_fail++; $display("FAIL rst_mem_ctl: we=%b cs=%b be=%h want 0 0 0", ifa.mem_write, ifa.mem_chipselect, ifa.mem_byteenable); end
    n_chk++; if (ifa.mem_address !== '0 || ifa.mem_writedata !== '0) begin
      n_fail++; $display("FAIL rst_mem_bus: addr=%0d data=%h want 0 0", ifa.mem_address, ifa.mem_writedata); end
    n_chk++; if (ifa.mem_clken !== 1'b1) begin
      n_fail++; $display("FAIL rst_clken: got %b want 1", ifa.mem_clken); end
    n_chk++; if (wr_ptr_a !== '0 || count_a !== '0 || wrapped_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_status: ptr=%0d cnt=%0d wrap=%b busy=%b done=%b want all 0",
                         wr_ptr_a, count_a, wrapped_a, busy_a, done_a); end
    n_chk++; if (ifa.snk_ready !== 1'b0 || ifb.snk_ready !== 1'b0 || drop_b !== 16'd0) begin
      n_fail++; $display("FAIL rst_ready_drop: rdy_a=%b rdy_b=%b drop=%0d want 0 0 0", ifa.snk_ready, ifb.snk_ready, drop_b); end
    reset_n = 1;
    cyc(1);
  endtask

  task automatic test_basic();
    do_reset();
    start_a = 1; cyc(1); start_a = 0;
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy_a); end
    for (int i = 0; i < 4; i++) begin
      ifa.snk_valid = 1; ifa.snk_data = 32'hA0 + i;
      n_chk++; if (ifa.snk_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready[%0d]: got %b want 1", i, ifa.snk_ready); end
      cyc(1);
      if (i == 0) begin
        n_chk++; if (ifa.mem_write !== 1'b0) begin n_fail++; $display("FAIL t1_lat_early: we=%b want 0", ifa.mem_write); end
      end
      if (i == 1) begin
        n_chk++; if (ifa.mem_write !== 1'b1 || ifa.mem_address !== 15'd0 || ifa.mem_writedata !== 32'hA0) begin
          n_fail++; $display("FAIL t1_lat_first: we=%b addr=%0d data=%h want 1 0 a0", ifa.mem_write, ifa.mem_address, ifa.mem_writedata); end
      end
    end
    ifa.snk_valid = 0;
    cyc(4);
    n_chk++; if (log_a.size() != 4) begin n_fail++; $display("FAIL t1_nwr: got %0d want 4", log_a.size()); end
    for (int i = 0; i < 4; i++) begin
      wr_t e;
      e = (i < log_a.size()) ? log_a[i] : '0;
      n_chk++; if (e.a !== AW'(i) || e.d !== DW'(32'hA0 + i) || e.be !== BE_ALL) begin
        n_fail++; $display("FAIL t1_wr[%0d]: addr=%0d data=%h be=%h want %0d %h f", i, e.a, e.d, e.be, i, 32'hA0 + i); end
    end
    n_chk++; if (wr_ptr_a !== 15'd4 || count_a !== 15'd4 || wrapped_a !== 1'b0) begin
      n_fail++; $display("FAIL t1_ptrs: ptr=%0d cnt=%0d wrap=%b want 4 4 0", wr_ptr_a, count_a, wrapped_a); end
  endtask

  task automatic test_wrap();
    do_reset();
    start_a = 1; cyc(1); start_a = 0;
    for (int i = 0; i < 10; i++) begin
      ifa.snk_valid = 1; ifa.snk_data = 32'hB0 + i;
      n_chk++; if (ifa.snk_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready[%0d]: got %b want 1", i, ifa.snk_ready); end
      cyc(1);
    end
    ifa.snk_valid = 0;
    cyc(4);
    n_chk++; if (log_a.size() != 10) begin n_fail++; $display("FAIL t2_nwr: got %0d want 10", log_a.size()); end
    for (int i = 0; i < 10; i++) begin
      wr_t e;
      e = (i < log_a.size()) ? log_a[i] : '0;
      n_chk++; if (e.a !== AW'(i % 8) || e.d !== DW'(32'hB0 + i)) begin
        n_fail++; $display("FAIL t2_wr[%0d]: addr=%0d data=%h want %0d %h", i, e.a, e.d, i % 8, 32'hB0 + i); end
    end
    n_chk++; if (wrapped_a !== 1'b1 || count_a !== 15'd8 || wr_ptr_a !== 15'd2) begin
      n_fail++; $display("FAIL t2_ptrs: wrap=%b cnt=%0d ptr=%0d want 1 8 2", wrapped_a, count_a, wr_ptr_a); end
    stop_a = 1; cyc(1); stop_a = 0;
    cyc(2);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t2_idle: busy=%b want 0", busy_a); end
  endtask

  task automatic test_hold_backpressure();
    int sent, cycles, hold_wr;
    do_reset();
    start_a = 1; cyc(1); start_a = 0;
    hold_a = 1;
    sent = 0; cycles = 0; hold_wr = 0;
    ifa.snk_valid = 1; ifa.snk_data = 32'hC0;
    while (sent < 6 && cycles < 50) begin
      logic acc;
      acc = ifa.snk_ready;
      cyc(1);
      cycles++;
      if (acc) begin
        sent++;
        if (sent < 6) ifa.snk_data = 32'hC0 + sent;
        else ifa.snk_valid = 0;
      end
      if (cycles <= 6 && ifa.mem_write !== 1'b0) hold_wr++;
      if (cycles == 4) begin
        n_chk++; if (ifa.snk_ready !== 1'b0 || sent != 4) begin
          n_fail++; $display("FAIL t3_stall: ready=%b accepted=%0d want 0 4", ifa.snk_ready, sent); end
      end
      if (cycles == 6) hold_a = 0;
    end
    ifa.snk_valid = 0; hold_a = 0;
    n_chk++; if (sent != 6) begin n_fail++; $display("FAIL t3_timeout: accepted=%0d want 6", sent); end
    n_chk++; if (hold_wr != 0) begin n_fail++; $display("FAIL t3_hold_wr: writes during hold=%0d want 0", hold_wr); end
    cyc(10);
    n_chk++; if (log_a.size() != 6) begin n_fail++; $display("FAIL t3_nwr: got %0d want 6", log_a.size()); end
    for (int i = 0; i < 6; i++) begin
      wr_t e;
      e = (i < log_a.size()) ? log_a[i] : '0;
      n_chk++; if (e.a !== AW'(i) || e.d !== DW'(32'hC0 + i)) begin
        n_fail++; $display("FAIL t3_wr[%0d]: addr=%0d data=%h want %0d %h", i, e.a, e.d, i, 32'hC0 + i); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    start_b = 1; cyc(1); start_b = 0;
    hold_b = 1;
    for (int i = 0; i < 6; i++) begin
      ifb.snk_valid = 1; ifb.snk_data = 32'hD0 + i;
      n_chk++; if (ifb.snk_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready[%0d]: got %b want 1", i, ifb.snk_ready); end
      cyc(1);
    end
    ifb.snk_valid = 0; hold_b = 0;
    cyc(8);
    n_chk++; if (log_b.size() != 4) begin n_fail++; $display("FAIL t4_nwr: got %0d want 4", log_b.size()); end
    for (int i = 0; i < 4; i++) begin
      wr_t e;
      e = (i < log_b.size()) ? log_b[i] : '0;
      n_chk++; if (e.a !== AW'(i) || e.d !== DW'(32'hD0 + i)) begin
        n_fail++; $display("FAIL t4_wr[%0d]: addr=%0d data=%h want %0d %h", i, e.a, e.d, i, 32'hD0 + i); end
    end
    n_chk++; if (drop_b !== 16'd2) begin n_fail++; $display("FAIL t4_drop: got %0d want 2", drop_b); end
  endtask

  task automatic test_clear();
    int pulses;
    do_reset();
    start_a = 1; cyc(1); start_a = 0;
    for (int i = 0; i < 9; i++) begin
      ifa.snk_valid = 1; ifa.snk_data = 32'hF0 + i;
      cyc(1);
    end
    ifa.snk_valid = 0;
    cyc(4);
    n_chk++; if (wrapped_a !== 1'b1 || count_a !== 15'd8 || wr_ptr_a !== 15'd1) begin
      n_fail++; $display("FAIL t5_pre: wrap=%b cnt=%0d ptr=%0d want 1 8 1", wrapped_a, count_a, wr_ptr_a); end
    hold_a = 1;
    for (int i = 0; i < 2; i++) begin
      ifa.snk_valid = 1; ifa.snk_data = 32'hE0 + i;
      cyc(1);
    end
    ifa.snk_valid = 0;
    log_a.delete();
    clear_a = 1; hold_a = 0; cyc(1); clear_a = 0;
    n_chk++; if (busy_a !== 1'b1 || count_a !== 15'd0 || wr_ptr_a !== 15'd0 || wrapped_a !== 1'b0) begin
      n_fail++; $display("FAIL t5_entry: busy=%b cnt=%0d ptr=%0d wrap=%b want 1 0 0 0", busy_a, count_a, wr_ptr_a, wrapped_a); end
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(1);
      if (done_a === 1'b1) pulses++;
    end
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL t5_done: pulses=%0d want 1", pulses); end
    n_chk++; if (log_a.size() != 8) begin n_fail++; $display("FAIL t5_nwr: got %0d want 8", log_a.size()); end
    for (int i = 0; i < 8; i++) begin
      wr_t e;
      e = (i < log_a.size()) ? log_a[i] : {AW'(15'h7FFF), DW'(32'hFFFFFFFF), 4'h0};
      n_chk++; if (e.a !== AW'(i) || e.d !== 32'h0 || e.be !== BE_ALL) begin
        n_fail++; $display("FAIL t5_wr[%0d]: addr=%0d data=%h be=%h want %0d 0 f", i, e.a, e.d, e.be, i); end
    end
    n_chk++; if (busy_a !== 1'b0 || count_a !== 15'd0 || wrapped_a !== 1'b0 || wr_ptr_a !== 15'd0) begin
      n_fail++; $display("FAIL t5_post: busy=%b cnt=%0d wrap=%b ptr=%0d want 0 0 0 0", busy_a, count_a, wrapped_a, wr_ptr_a); end
  endtask

  task automatic test_async_reset();
    do_reset();
    clear_a = 1; cyc(1); clear_a = 0;
    cyc(3);
    n_chk++; if (ifa.mem_write !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL t6_pre: we=%b busy=%b want 1 1", ifa.mem_write, busy_a); end
    #2 reset_n = 0;
    #1;
    n_chk++; if (ifa.mem_write !== 1'b0 || ifa.mem_chipselect !== 1'b0 || ifa.mem_byteenable !== 4'h0) begin
      n_fail++; $display("FAIL t6_async_we: we=%b cs=%b be=%h want 0 0 0", ifa.mem_write, ifa.mem_chipselect, ifa.mem_byteenable); end
    n_chk++; if (ifa.mem_address !== '0 || busy_a !== 1'b0 || count_a !== '0 || ifa.mem_clken !== 1'b1) begin
      n_fail++; $display("FAIL t6_async_state: addr=%0d busy=%b cnt=%0d clken=%b want 0 0 0 1",
                         ifa.mem_address, busy_a, count_a, ifa.mem_clken); end
    cyc(1);
    reset_n = 1;
    cyc(2);
    n_chk++; if (busy_a !== 1'b0 || ifa.mem_write !== 1'b0 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL t6_release: busy=%b we=%b done=%b want 0 0 0", busy_a, ifa.mem_write, done_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold_backpressure();
    test_drop();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
